// File: rtl/aes_batch_sequencer.sv
// Batch plaintext sequencer in front of the AES core: runs N encryptions per start,
// XOR-folds ciphertexts into chk. Define AES_SEQ_CHAIN_EN to feed ciphertext back as plaintext.
//
// state | meaning
// IDLE  | waiting for start; done/err hold their last value
// LOAD  | check remaining/abort, wait for core not busy
// ISSUE | drdy pulse with din to the core
// WAIT  | wait for dvld, TMO_CYC cycle budget
// GAP   | trace separation before the next plaintext
// FIN   | one-cycle batch end
module aes_batch_sequencer #(
  parameter int CNT_W   = 16,
  parameter int GAP_CYC = 16,
  parameter int TMO_CYC = 255
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] count,
  input  logic [127:0]     seed,
  output logic [127:0]     din,
  output logic             drdy,
  input  logic [127:0]     dout,
  input  logic             dvld,
  input  logic             bsy,
  output logic             trig,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] idx,
  output logic [127:0]     chk
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_GAP, S_FIN} state_t;

  localparam int TMR_W = 16;
  localparam logic [TMR_W-1:0] TMO_LD = TMR_W'(TMO_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LD = TMR_W'(GAP_CYC);

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               abort_pend_q, abort_pend_d;
  logic [127:0]       lfsr_q, lfsr_d;
  logic [127:0]       din_q, din_d;
  logic               drdy_q, drdy_d;
  logic               trig_q, trig_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [127:0]       chk_q, chk_d;
`ifdef AES_SEQ_CHAIN_EN
  logic [127:0]       pt_q, pt_d;
  logic               chain_v_q, chain_v_d;
`endif

  function automatic logic [127:0] lfsr_step(input logic [127:0] l);
    return {l[126:0], 1'b0} ^ (l[127] ? 128'h87 : 128'h0);
  endfunction

  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    rem_d        = rem_q;
    abort_pend_d = abort_pend_q;
    lfsr_d       = lfsr_q;
    din_d        = din_q;
    drdy_d       = 1'b0;
    trig_d       = trig_q;
    done_d       = done_q;
    err_d        = err_q;
    idx_d        = idx_q;
    chk_d        = chk_q;
`ifdef AES_SEQ_CHAIN_EN
    pt_d         = pt_q;
    chain_v_d    = chain_v_q;
`endif

    if (state_q != S_IDLE && abort) abort_pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        // start wins over a simultaneous abort; both clear any stale abort
        if (start) begin
          state_d      = S_LOAD;
          done_d       = 1'b0;
          err_d        = 1'b0;
          idx_d        = '0;
          chk_d        = '0;
          rem_d        = count;
          abort_pend_d = 1'b0;
          lfsr_d       = (seed == 128'h0) ? 128'h1 : seed;
`ifdef AES_SEQ_CHAIN_EN
          chain_v_d    = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (rem_q == '0 || abort_pend_q) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else if (!bsy) begin
          state_d = S_ISSUE;
          drdy_d  = 1'b1;
          trig_d  = 1'b1;
          tmr_d   = TMO_LD;
`ifdef AES_SEQ_CHAIN_EN
          din_d   = chain_v_q ? pt_q : lfsr_q;
`else
          din_d   = lfsr_q;
`endif
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (dvld) begin
          state_d = S_GAP;
          chk_d   = chk_q ^ dout;
          rem_d   = rem_q - 1'b1;
          trig_d  = 1'b0;
          lfsr_d  = lfsr_step(lfsr_q);
          tmr_d   = GAP_LD;
          if (idx_q != '1) idx_d = idx_q + 1'b1;
`ifdef AES_SEQ_CHAIN_EN
          pt_d      = dout;
          chain_v_d = 1'b1;
`endif
        end else if (tmr_q == '0) begin
          state_d = S_FIN;
          err_d   = 1'b1;
          done_d  = 1'b1;
          trig_d  = 1'b0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_GAP: begin
        // gap timer runs GAP_LD..0, so the gap spans GAP_CYC+1 cycles
        if (tmr_q == '0) begin
          if (abort_pend_q) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q      <= S_IDLE;
      tmr_q        <= '0;
      rem_q        <= '0;
      abort_pend_q <= 1'b0;
      lfsr_q       <= '0;
      din_q        <= '0;
      drdy_q       <= 1'b0;
      trig_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      idx_q        <= '0;
      chk_q        <= '0;
`ifdef AES_SEQ_CHAIN_EN
      pt_q         <= '0;
      chain_v_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      rem_q        <= rem_d;
      abort_pend_q <= abort_pend_d;
      lfsr_q       <= lfsr_d;
      din_q        <= din_d;
      drdy_q       <= drdy_d;
      trig_q       <= trig_d;
      done_q       <= done_d;
      err_q        <= err_d;
      idx_q        <= idx_d;
      chk_q        <= chk_d;
`ifdef AES_SEQ_CHAIN_EN
      pt_q         <= pt_d;
      chain_v_q    <= chain_v_d;
`endif
    end
  end

  assign din  = din_q;
  assign drdy = drdy_q;
  assign trig = trig_q;
  assign done = done_q;
  assign err  = err_q;
  assign idx  = idx_q;
  assign chk  = chk_q;

endmodule

// File: tb/tb_aes_batch_sequencer.sv
// Scoreboard bench for aes_batch_sequencer: expected plaintexts and batch results are queued
// by the stimulus, popped by monitors on drdy and on the rising edge of done.
module tb_aes_batch_sequencer;

  localparam int CORE_LAT = 20;
  localparam int PERIOD   = CORE_LAT + 16 + 3;

  typedef struct packed {
    logic [15:0]  idx;
    logic [127:0] chk;
    logic         err;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i, abort_i;
  logic [15:0]  count_i;
  logic [127:0] seed_i;
  logic [127:0] din;
  logic         drdy, trig, done, err;
  logic [15:0]  idx;
  logic [127:0] chk;

  logic         dvld_core = 1'b0;
  logic         dvld_x = 1'b0;
  logic [127:0] dout_core = '0;
  logic [127:0] dout_x = '0;
  logic         dvld_w, bsy_w;
  logic [127:0] dout_w;
  int           core_cnt = 0;
  bit           core_on = 1'b1;

  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  int           done_seen = 0;
  int           exp_batches = 0;
  int           start_cyc = 0;
  logic         done_prev = 1'b0;
  res_t         mon_r;

  logic [127:0] exp_din[$];
  res_t         exp_res[$];
  int           drdy_log[$];

  assign dvld_w = dvld_core | dvld_x;
  assign dout_w = dvld_x ? dout_x : dout_core;
  assign bsy_w  = (core_cnt != 0);

  aes_batch_sequencer dut (
    .CLK   (clk),
    .RSTn  (rst_n),
    .start (start_i),
    .abort (abort_i),
    .count (count_i),
    .seed  (seed_i),
    .din   (din),
    .drdy  (drdy),
    .dout  (dout_w),
    .dvld  (dvld_w),
    .bsy   (bsy_w),
    .trig  (trig),
    .done  (done),
    .err   (err),
    .idx   (idx),
    .chk   (chk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // behavioural core: dvld CORE_LAT cycles after the drdy cycle, dout = din ^ 'hFF
  always @(negedge clk) begin
    dvld_core = 1'b0;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) dvld_core = 1'b1;
    end
    if (core_on && rst_n && drdy) begin
      core_cnt  = CORE_LAT;
      dout_core = din ^ 128'hFF;
    end
  end

  always @(negedge clk) begin
    if (rst_n && drdy) begin
      drdy_log.push_back(cyc);
      if (exp_din.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_drdy actual=%h expected=none", din);
      end else begin
        check("din", din, exp_din.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done && !done_prev) begin
      done_seen++;
      if (exp_res.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual idx=%0d chk=%h err=%b expected=none", idx, chk, err);
      end else begin
        mon_r = exp_res.pop_front();
        check("done_idx", idx, mon_r.idx);
        check("done_chk", chk, mon_r.chk);
        check("done_err", err, mon_r.err);
      end
    end
    done_prev = done;
  end

  task automatic push_res(input logic [15:0] i, input logic [127:0] c, input logic e);
    res_t r;
    r.idx = i;
    r.chk = c;
    r.err = e;
    exp_res.push_back(r);
    exp_batches++;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic run_start(input logic [127:0] s, input logic [15:0] c);
    @(negedge clk);
    drdy_log.delete();
    seed_i    = s;
    count_i   = c;
    start_i   = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_drdy(input int n);
    int k = 0;
    while (drdy_log.size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("drdy_seen", 128'(drdy_log.size()), 128'(n));
  endtask

  task automatic wait_batch();
    int k = 0;
    while (done_seen < exp_batches && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("batch_complete", 128'(done_seen), 128'(exp_batches));
  endtask

  task automatic run_basic(input logic [127:0] s, input logic [127:0] d0, input logic [127:0] d1,
                           input logic [127:0] d2, input logic [127:0] c);
    int n0;
    exp_din.push_back(d0);
    exp_din.push_back(d1);
    exp_din.push_back(d2);
    push_res(16'd3, c, 1'b0);
    run_start(s, 16'd3);
    wait_drdy(1);
    n0 = drdy_log[0];
    check("start_to_drdy", 128'(n0 - start_cyc), 128'd2);
    wait_cyc(n0 + CORE_LAT);
    check("trig_in_dvld_cycle", trig, 1'b1);
    wait_cyc(n0 + CORE_LAT + 1);
    check("trig_after_dvld", trig, 1'b0);
    wait_batch();
    check("drdy_pulses", 128'(drdy_log.size()), 128'd3);
    if (drdy_log.size() == 3) begin
      check("spacing_1_2", 128'(drdy_log[1] - drdy_log[0]), 128'(PERIOD));
      check("spacing_2_3", 128'(drdy_log[2] - drdy_log[1]), 128'(PERIOD));
    end
  endtask

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m;
    logic [127:0] top_bit;
    logic [127:0] d2, c2;

    rst_n   = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    count_i = '0;
    seed_i  = '0;
    repeat (3) @(negedge clk);
    check("rst_din", din, 128'h0);
    check("rst_drdy", drdy, 1'b0);
    check("rst_trig", trig, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_idx", idx, 16'h0);
    check("rst_chk", chk, 128'h0);
    rst_n = 1'b1;

`ifdef AES_SEQ_CHAIN_EN
    run_basic(128'h5, 128'h5, 128'hFA, 128'h05, 128'h05);
`else
    run_basic(128'h1, 128'h1, 128'h2, 128'h4, 128'hF8);
`endif

    // zero seed falls back to 1
    exp_din.push_back(128'h1);
    push_res(16'd1, 128'hFE, 1'b0);
    run_start(128'h0, 16'd1);
    wait_batch();

    // top bit set: the next LFSR step folds in 'h87
    top_bit = 128'h0;
    top_bit[127] = 1'b1;
`ifdef AES_SEQ_CHAIN_EN
    d2 = top_bit ^ 128'hFF;
    c2 = 128'hFF;
`else
    d2 = 128'h87;
    c2 = top_bit ^ 128'h87;
`endif
    exp_din.push_back(top_bit);
    exp_din.push_back(d2);
    push_res(16'd2, c2, 1'b0);
    run_start(top_bit, 16'd2);
    wait_batch();

    push_res(16'd0, 128'h0, 1'b0);
    run_start(128'h9, 16'd0);
    check("cnt0_done_in_load", done, 1'b0);
    @(negedge clk);
    check("cnt0_done_two_cycles", done, 1'b1);
    check("cnt0_no_drdy", 128'(drdy_log.size()), 128'd0);
    wait_batch();

    // silent core: timeout
    core_on = 1'b0;
    exp_din.push_back(128'h3);
    push_res(16'd0, 128'h0, 1'b1);
    run_start(128'h3, 16'd1);
    wait_drdy(1);
    n = drdy_log[0];
    wait_cyc(n + 255);
    check("tmo_trig_before", trig, 1'b1);
    check("tmo_err_before", err, 1'b0);
    wait_cyc(n + 256);
    check("tmo_err", err, 1'b1);
    check("tmo_done", done, 1'b1);
    check("tmo_trig", trig, 1'b0);
    check("tmo_idx", idx, 16'h0);
    wait_batch();
    core_on = 1'b1;

    // abort, start-in-WAIT and stray dvld in GAP
    exp_din.push_back(128'h1);
`ifdef AES_SEQ_CHAIN_EN
    exp_din.push_back(128'hFE);
    push_res(16'd2, 128'hFF, 1'b0);
`else
    exp_din.push_back(128'h2);
    push_res(16'd2, 128'h3, 1'b0);
`endif
    run_start(128'h1, 16'd10);
    wait_drdy(1);
    n = drdy_log[0];
    wait_cyc(n + 3);
    start_i = 1'b1;
    seed_i  = 128'h55;
    count_i = 16'd1;
    wait_cyc(n + 4);
    start_i = 1'b0;
    wait_cyc(n + 5);
    check("start_in_wait_trig", trig, 1'b1);
    wait_cyc(n + 25);
    dvld_x = 1'b1;
    dout_x = 128'hAAAA_5555;
    wait_cyc(n + 26);
    dvld_x = 1'b0;
    check("stray_dvld_chk", chk, 128'hFE);
    check("stray_dvld_idx", idx, 16'h1);
    wait_drdy(2);
    m = drdy_log[1];
    check("abort_run_spacing", 128'(m - n), 128'(PERIOD));
    wait_cyc(m + 5);
    abort_i = 1'b1;
    wait_cyc(m + 6);
    abort_i = 1'b0;
    wait_batch();
    wait_cyc(cyc + 60);
    check("abort_drdy_count", 128'(drdy_log.size()), 128'd2);

    // reset in WAIT abandons the batch; late dvld lands in IDLE
    exp_din.push_back(128'h1);
    run_start(128'h1, 16'd1);
    wait_drdy(1);
    n = drdy_log[0];
    wait_cyc(n + 2);
    check("pre_rst_trig", trig, 1'b1);
    rst_n = 1'b0;
    wait_cyc(n + 3);
    check("mid_rst_trig", trig, 1'b0);
    check("mid_rst_drdy", drdy, 1'b0);
    check("mid_rst_din", din, 128'h0);
    check("mid_rst_idx", idx, 16'h0);
    check("mid_rst_chk", chk, 128'h0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_err", err, 1'b0);
    rst_n = 1'b1;
    wait_cyc(n + 30);
    check("idle_dvld_chk", chk, 128'h0);
    check("idle_dvld_idx", idx, 16'h0);
    check("idle_dvld_done", done, 1'b0);

    check("exp_din_drained", 128'(exp_din.size()), 128'd0);
    check("exp_res_drained", 128'(exp_res.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
